truncamiento_sat_pipe: RTL and testbench
========================================

// Module: truncamiento_sat_pipe
// PURPOSE
//  Pipelined fixed-point truncation/saturation stage for the datapath's multiplier products.
//  Takes a full-precision 2N-bit two's-complement product with 2F fraction bits.
//  Produces an N-bit sign/integer/fraction word: 1 sign bit, P integer bits, F = N-1-P fraction bits.
//  Rounding mode is selectable per sample. The output saturates on overflow.
//  Valid/ready handshake on both sides; sits between the multiplier and the accumulator/filter.
// PARAMETERS
//  N  8  output word width (sign + integer + fraction)
//  P  3  integer (magnitude) bits; F = N-1-P, must be >= 1
// PORTS
//  clk          in   1    clock, rising edge
//  reset        in   1    synchronous, active-high reset
//  in_valid     in   1    input sample valid
//  in_ready     out  1    block accepts a sample this cycle
//  Datos_Sum    in   2N   signed product, 2F fraction bits
//  round_en     in   1    1 = round-half-up, 0 = truncate (floor); sampled with the data
//  out_valid    out  1    output sample valid
//  out_ready    in   1    downstream accepts the sample
//  Datos_Trunc  out  N    signed result, F fraction bits
//  out_sat      out  1    Datos_Trunc was saturated (qualified by out_valid)
//  clr_ovf      in   1    one-cycle pulse: clears ovf_sticky (and sat_count)
//  ovf_sticky   out  1    set by any saturated sample entering stage 2
//  sat_count    out  16   saturation event count (see CONFIGURATION)
// BEHAVIOUR
//  Reset values
//   - A synchronous reset clears both stage valids, Datos_Trunc, out_sat, ovf_sticky and sat_count to 0.
//   - Reset mid-operation drops in-flight samples; no output transfer occurs in the reset cycle.
//  Flow control
//   - Two register stages: en = !out_valid | out_ready; in_ready = en (combinational from out_ready).
//   - Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
//   - Latency is 2 cycles with no stall; one sample per cycle when out_ready is held at 1.
//   - When en = 0, all stages hold and data/out_sat stay stable; bubbles propagate as stage valid = 0.
//  Stage 1 (on en)
//   - s1_val <= in_valid.
//   - s1 <= Datos_Sum + (round_en ? 2^(F-1) : 0), computed in 2N+1 bits so no wrap.
//  Stage 2 (on en)
//   - t = s1 >>> F (arithmetic shift).
//   - If t > 2^(N-1)-1: Datos_Trunc = 0x7F.. (max) and out_sat = 1.
//   - If t < -2^(N-1): Datos_Trunc = 0x80.. (min) and out_sat = 1.
//   - Otherwise Datos_Trunc = t[N-1:0] and out_sat = 0.
//   - out_valid <= s1_val.
//  Sticky flag and clear
//   - ovf_sticky sets when stage 2 loads a valid saturated sample.
//   - clr_ovf clears ovf_sticky; if set and clear happen in the same cycle, set wins.
// CONFIGURATION
//  Macro: TRUNC_SAT_CNT_EN
//  Defined
//   - sat_count increments on each output transfer with out_sat = 1.
//   - It sticks at 0xFFFF and does not wrap.
//   - clr_ovf clears it; increment and clear in the same cycle gives 1.
//  Undefined
//   - sat_count is tied to 0 and no counter logic is built; all other behaviour is identical.
// TESTING (N=8, P=3, F=4; input has 8 fraction bits)
//  - In-range value: 0x0300 (3.0), round_en=0, out_ready=1
//    -> 2 cycles later Datos_Trunc=0x30, out_sat=0.
//  - Positive overflow: 0x3840 (56.25)
//    -> Datos_Trunc=0x7F, out_sat=1, ovf_sticky=1.
//    -> Then pulse clr_ovf -> ovf_sticky=0.
//  - Negative overflow: 0xC080 (-63.5) -> Datos_Trunc=0x80, out_sat=1.
//  - Rounding: 0x0018 gives 0x01 with round_en=0 and 0x02 with round_en=1.
//    0xFFF8 gives 0xFF with round_en=0 and 0x00 with round_en=1.
//  - Backpressure: stream 5 samples with out_ready=0 for 4 cycles.
//    -> in_ready drops once both stages are full; all 5 outputs arrive in order, no loss or duplication.
//    -> Reset asserted mid-stream -> out_valid=0 on the next cycle.
//  - With TRUNC_SAT_CNT_EN: 3 saturated transfers -> sat_count=3.
//    -> Saturation in the same cycle as clr_ovf -> sat_count=1.

Source files
------------

// File: rtl/truncamiento_sat_pipe.sv
// truncamiento_sat_pipe
//   Two-stage fixed-point truncation/saturation stage for multiplier products.
//   A 2N-bit two's-complement product with 2F fraction bits becomes an N-bit
//   word (1 sign, P integer, F = N-1-P fraction bits). The first stage applies
//   an optional round-half-up bias. The second stage drops F bits and clamps
//   the result to the N-bit range.
//
//   Ports
//     clk          rising-edge clock
//     reset        synchronous, active-high reset
//     in_valid     input sample valid
//     in_ready     block accepts a sample this cycle
//     Datos_Sum    signed product, 2F fraction bits (2N bits)
//     round_en     1 = round-half-up, 0 = floor; travels with the sample
//     out_valid    output sample valid
//     out_ready    downstream accepts the sample
//     Datos_Trunc  signed result, F fraction bits (N bits)
//     out_sat      Datos_Trunc was clamped (qualified by out_valid)
//     clr_ovf      pulse: clears ovf_sticky and sat_count
//     ovf_sticky   set by any saturated sample loaded into stage 2
//     sat_count    saturated output transfers, saturating at 0xFFFF
//
//   Build option
//     TRUNC_SAT_CNT_EN  when defined, sat_count is a live counter;
//                       otherwise it is tied to 0 and no counter is built.
module truncamiento_sat_pipe #(
  parameter int N = 8,
  parameter int P = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [2*N-1:0] Datos_Sum,
  input  logic                  round_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [N-1:0]   Datos_Trunc,
  output logic                  out_sat,
  input  logic                  clr_ovf,
  output logic                  ovf_sticky,
  output logic [15:0]           sat_count
);

  localparam int F = N - 1 - P;
  localparam int W = 2 * N;

  // Output range limits held in the widened stage-1 width so the compare is
  // fully signed. ~MAXV equals -2^(N-1).
  localparam logic signed [W:0] MAXV = signed'((W+1)'((1 << (N-1)) - 1));
  localparam logic signed [W:0] MINV = ~MAXV;

  // Sign-extend by one bit before adding the half-LSB bias so the largest
  // positive product cannot wrap.
  function automatic logic signed [W:0] round_add(input logic signed [W-1:0] x,
                                                  input logic rnd);
    logic signed [W:0] bias;
    bias = '0;
    if (rnd) bias[F-1] = 1'b1;
    return {x[W-1], x} + bias;
  endfunction

  // Returns {saturated, result}.
  function automatic logic [N:0] sat_trunc(input logic signed [W:0] s);
    logic signed [W:0] t;
    t = s >>> F;
    if (t > MAXV)      return {1'b1, MAXV[N-1:0]};
    else if (t < MINV) return {1'b1, MINV[N-1:0]};
    else               return {1'b0, t[N-1:0]};
  endfunction

  logic              en;
  logic              vld_p1_q;
  logic signed [W:0] sum_p1_q;
  logic signed [W:0] sum_p1_d;
  logic              vld_p2_q;
  logic [N-1:0]      trunc_p2_q;
  logic              sat_p2_q;
  logic [N:0]        sat_word_d;
  logic              sticky_q;

  // Both stages advance together whenever the output slot is free or drains.
  assign en       = !vld_p2_q | out_ready;
  assign in_ready = en;

  assign sum_p1_d   = round_add(Datos_Sum, round_en);
  assign sat_word_d = sat_trunc(sum_p1_q);

  // Stage 1: rounding bias
  always_ff @(posedge clk) begin
    if (reset)   vld_p1_q <= 1'b0;
    else if (en) vld_p1_q <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (en) sum_p1_q <= sum_p1_d;
  end

  // Stage 2: truncate and clamp
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p2_q   <= 1'b0;
      trunc_p2_q <= '0;
      sat_p2_q   <= 1'b0;
    end else if (en) begin
      vld_p2_q   <= vld_p1_q;
      trunc_p2_q <= sat_word_d[N-1:0];
      sat_p2_q   <= sat_word_d[N];
    end
  end

  // A saturated sample arriving in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset)                                sticky_q <= 1'b0;
    else if (en && vld_p1_q && sat_word_d[N]) sticky_q <= 1'b1;
    else if (clr_ovf)                         sticky_q <= 1'b0;
  end

  assign out_valid   = vld_p2_q;
  assign Datos_Trunc = signed'(trunc_p2_q);
  assign out_sat     = sat_p2_q;
  assign ovf_sticky  = sticky_q;

`ifdef TRUNC_SAT_CNT_EN
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic        cnt_inc;

  assign cnt_inc = vld_p2_q & out_ready & sat_p2_q;

  // Clear and increment together restart the count at 1; the count holds at
  // all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_ovf)                        cnt_d = {15'd0, cnt_inc};
    else if (cnt_inc && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign sat_count = cnt_q;
`else
  assign sat_count = '0;
`endif

endmodule

// File: tb/tb_truncamiento_sat_pipe.sv
module tb_truncamiento_sat_pipe;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] Datos_Sum;
  logic               round_en;
  logic               out_valid;
  logic               out_ready;
  logic signed [7:0]  Datos_Trunc;
  logic               out_sat;
  logic               clr_ovf;
  logic               ovf_sticky;
  logic [15:0]        sat_count;

  int checks = 0;
  int passes = 0;

  truncamiento_sat_pipe #(.N(8), .P(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .Datos_Sum  (Datos_Sum),
    .round_en   (round_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .Datos_Trunc(Datos_Trunc),
    .out_sat    (out_sat),
    .clr_ovf    (clr_ovf),
    .ovf_sticky (ovf_sticky),
    .sat_count  (sat_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One isolated sample with out_ready held high; result appears two edges later.
  task automatic send_one(input string tag, input logic [15:0] d, input logic rnd,
                          input logic [7:0] exp_d, input logic exp_s);
    in_valid  = 1'b1;
    Datos_Sum = d;
    round_en  = rnd;
    step();
    in_valid = 1'b0;
    step();
    check({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_dat"}, {24'd0, Datos_Trunc}, {24'd0, exp_d});
    check({tag, "_sat"}, {31'd0, out_sat}, {31'd0, exp_s});
  endtask

  initial begin
    logic [7:0] exp_q[5];
    int in_idx;
    int out_idx;

    reset = 1'b1; in_valid = 1'b0; Datos_Sum = '0; round_en = 1'b0;
    out_ready = 1'b1; clr_ovf = 1'b0;
    step(); step();
    check("rst_vld",    {31'd0, out_valid},  32'd0);
    check("rst_dat",    {24'd0, Datos_Trunc}, 32'd0);
    check("rst_sat",    {31'd0, out_sat},    32'd0);
    check("rst_sticky", {31'd0, ovf_sticky}, 32'd0);
    check("rst_cnt",    {16'd0, sat_count},  32'd0);
    check("rst_rdy",    {31'd0, in_ready},   32'd1);
    reset = 1'b0;
    step();

    // In range, then latency: output not valid after one edge
    in_valid = 1'b1; Datos_Sum = 16'h0300; round_en = 1'b0;
    step();
    in_valid = 1'b0;
    check("lat1_vld", {31'd0, out_valid}, 32'd0);
    step();
    check("inrng_vld", {31'd0, out_valid}, 32'd1);
    check("inrng_dat", {24'd0, Datos_Trunc}, 32'h30);
    check("inrng_sat", {31'd0, out_sat}, 32'd0);
    step();
    check("bubble_vld", {31'd0, out_valid}, 32'd0);

    send_one("posovf", 16'h3840, 1'b0, 8'h7F, 1'b1);
    check("posovf_sticky", {31'd0, ovf_sticky}, 32'd1);
    clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
    check("clr_sticky", {31'd0, ovf_sticky}, 32'd0);

    send_one("negovf", 16'hC080, 1'b0, 8'h80, 1'b1);
    clr_ovf = 1'b1; step(); clr_ovf = 1'b0;

    send_one("rnd_p0", 16'h0018, 1'b0, 8'h01, 1'b0);
    send_one("rnd_p1", 16'h0018, 1'b1, 8'h02, 1'b0);
    send_one("rnd_n0", 16'hFFF8, 1'b0, 8'hFF, 1'b0);
    send_one("rnd_n1", 16'hFFF8, 1'b1, 8'h00, 1'b0);
    send_one("maxpos", 16'h07F0, 1'b0, 8'h7F, 1'b0);
    send_one("rnd_ovf", 16'h07F8, 1'b1, 8'h7F, 1'b1);
    send_one("minneg", 16'hF800, 1'b0, 8'h80, 1'b0);
    check("sticky_after", {31'd0, ovf_sticky}, 32'd1);

    // Set wins over a simultaneous clear: clear pulsed while the saturated
    // sample moves from stage 1 into stage 2.
    clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
    check("sticky_clr0", {31'd0, ovf_sticky}, 32'd0);
    in_valid = 1'b1; Datos_Sum = 16'h3840; round_en = 1'b0;
    step();
    in_valid = 1'b0; clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("set_wins", {31'd0, ovf_sticky}, 32'd1);
    clr_ovf = 1'b1; step(); clr_ovf = 1'b0;

    // Backpressure: five samples, out_ready low for the first four cycles
    for (int i = 0; i < 5; i++) exp_q[i] = 8'(i + 1);
    in_idx = 0; out_idx = 0;
    for (int cyc = 0; cyc < 30 && out_idx < 5; cyc++) begin
      in_valid  = (in_idx < 5);
      Datos_Sum = 16'(16 * (in_idx + 1));
      round_en  = 1'b0;
      out_ready = (cyc >= 4);
      #1;
      if (cyc == 2) check("bp_rdy_low", {31'd0, in_ready}, 32'd0);
      if (cyc == 3) check("bp_hold", {24'd0, Datos_Trunc}, 32'h01);
      if (in_valid && in_ready) in_idx++;
      if (out_valid && out_ready) begin
        check("bp_order", {24'd0, Datos_Trunc}, {24'd0, exp_q[out_idx]});
        out_idx++;
      end
      step();
    end
    check("bp_count", out_idx, 32'd5);
    in_valid = 1'b0; out_ready = 1'b1;
    step(); step();

    // Reset with a full pipe drops everything
    in_valid = 1'b1; Datos_Sum = 16'h3840;
    step(); step();
    reset = 1'b1; in_valid = 1'b0;
    step();
    check("midrst_vld", {31'd0, out_valid}, 32'd0);
    check("midrst_sat", {31'd0, out_sat}, 32'd0);
    check("midrst_sticky", {31'd0, ovf_sticky}, 32'd0);
    reset = 1'b0;
    step();

    // Three saturated transfers
    in_valid = 1'b1; Datos_Sum = 16'hC080; round_en = 1'b0;
    step(); step(); step();
    in_valid = 1'b0;
    step(); step(); step();
`ifdef TRUNC_SAT_CNT_EN
    check("cnt3", {16'd0, sat_count}, 32'd3);
`else
    check("cnt_tied", {16'd0, sat_count}, 32'd0);
`endif

    // Saturated transfer in the same cycle as the clear
    in_valid = 1'b1; Datos_Sum = 16'h3840;
    step();
    in_valid = 1'b0;
    step();
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
`ifdef TRUNC_SAT_CNT_EN
    check("cnt_clr_inc", {16'd0, sat_count}, 32'd1);
`else
    check("cnt_tied2", {16'd0, sat_count}, 32'd0);
`endif
    check("sticky_cleared", {31'd0, ovf_sticky}, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
